prefix_stream_accum: RTL
========================

Name: prefix_stream_accum

Overview:
- Sequential stage directly downstream of the combinational prefix-sum adder.
- Consumes one adder result per beat over a valid/ready stream and emits the running (inclusive) prefix sum of all beats in the current packet.
- Tracks per-packet beat count and sticky carry-out, and resets the running sum at packet boundaries.
- Output is registered, giving a clean timing boundary after the adder.

Parameters:
- N, 32, data width of input beats and output sums.
- CNT_W, 16, width of the per-packet beat counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- IN_valid  input  1  upstream beat valid.
- OUT_ready  output  1  this block can accept a beat this cycle.
- IN_data  input  N  adder result for this beat.
- IN_last  input  1  beat is the final beat of its packet.
- IN_clear  input  1  abort the current packet and zero the accumulator.
- OUT_valid  output  1  output register holds a valid prefix sum.
- IN_ready  input  1  downstream accepts the output this cycle.
- OUT_data  output  N  inclusive prefix sum, modulo 2^N.
- OUT_last  output  1  output beat closes its packet.
- OUT_count  output  CNT_W  1-based beat index within the packet, saturating.
- OUT_carry  output  1  sticky: some addition in this packet, up to and including this beat, carried out of bit N-1.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - OUT_valid=0, OUT_data=0, OUT_last=0, OUT_count=0, OUT_carry=0.
  - Internal acc=0, cnt=0, carry=0, state=IDLE.
  - Reset overrides every other input, including mid-packet; any packet in progress is lost.
- Handshake:
  - OUT_ready = !OUT_valid || IN_ready. This is combinational, giving a one-entry pipeline register with full throughput.
  - Accept = IN_valid && OUT_ready.
  - Output transfer = OUT_valid && IN_ready.
  - Output fields are held stable while OUT_valid && !IN_ready.
- Latency: an accepted beat appears on the outputs the next cycle. Throughput is 1 beat/cycle while IN_ready=1.
- Per accepted beat:
  - sum = acc + IN_data, computed at N+1 bits.
  - OUT_data <= sum[N-1:0]; acc <= sum[N-1:0].
  - carry_new = carry || sum[N]; OUT_carry <= carry_new; carry <= carry_new.
  - cnt_new = cnt + 1, saturating at 2^CNT_W-1; OUT_count <= cnt_new; cnt <= cnt_new.
  - OUT_last <= IN_last; OUT_valid <= 1.
- If IN_last is accepted, then after the update acc=0, cnt=0, carry=0, state=IDLE. The next beat starts a fresh packet.
- Transfer without a new accept: OUT_valid <= 0; the other output fields hold their values.
- State machine:
  - IDLE: no packet open. An accept with IN_last=0 goes to RUN; an accept with IN_last=1 stays in IDLE (single-beat packet).
  - RUN: packet open. An accept with IN_last=1 goes to IDLE; IN_clear goes to IDLE.
- IN_clear:
  - Zeroes acc, cnt and carry and forces IDLE.
  - Does not drop a beat already sitting in the output register.
- Simultaneous IN_clear and accept: the clear takes effect first. The beat is processed as beat 1 of a new packet (OUT_data=IN_data, OUT_count=1, OUT_carry=0). Its IN_last applies normally.
- IN_clear without an accept: state update only; no output change.
- Wrap-around: OUT_data wraps modulo 2^N. The wrap is reported only via OUT_carry.
- Count saturation: OUT_count holds at its maximum once reached. The sum continues to accumulate.
- IN_valid=0: inputs are ignored, including IN_data and IN_last. IN_clear is still honoured.

Test Plan:
- Basic stream: packet 1,2,3,4 (last on 4) with IN_ready=1 -> OUT_data 1,3,6,10; OUT_count 1..4; OUT_last only on 10; OUT_carry=0; next packet beat 5 -> OUT_data=5, OUT_count=1.
- Backpressure: IN_ready=0 for 3 cycles during a packet with IN_valid held -> OUT_ready=0 while the output is full; OUT_data stays 3 unchanged; no beat lost or duplicated; the sequence resumes as 6,10.
- Wrap, N=32: beats 0xFFFFFFF0, 0x20 (last) -> OUT_data 0xFFFFFFF0 then 0x00000010; OUT_carry 0 then 1; the following packet's first beat has OUT_carry=0.
- Clear: beats 7,8, then IN_clear asserted together with accept of beat 5 -> outputs 7, 15, then 5 with OUT_count=1.
- Reset mid-packet: after beats 1,2, pull rst_n low for 1 cycle -> all outputs 0 the following cycle; a subsequent beat 9 -> OUT_data=9, OUT_count=1.
- Count saturation, CNT_W=2: 5 beats of 1 (last on 5th) -> OUT_count 1,2,3,3,3; OUT_data 1..5.

Source files
------------

// File: rtl/prefix_stream_accum_if.sv
// Stream bundle for prefix_stream_accum.
// Input side:  IN_valid/OUT_ready handshake carrying IN_data, IN_last, and an
//              out-of-band IN_clear.
// Output side: OUT_valid/IN_ready handshake carrying OUT_data, OUT_last,
//              OUT_count and OUT_carry.
// Modport slave is the accumulator's view. Modport master is the
// environment's view.
interface prefix_stream_accum_if #(
   parameter int unsigned N     = 32,
   parameter int unsigned CNT_W = 16
);
   logic             IN_valid;
   logic             OUT_ready;
   logic [N-1:0]     IN_data;
   logic             IN_last;
   logic             IN_clear;
   logic             OUT_valid;
   logic             IN_ready;
   logic [N-1:0]     OUT_data;
   logic             OUT_last;
   logic [CNT_W-1:0] OUT_count;
   logic             OUT_carry;

   modport slave (
      input  IN_valid, IN_data, IN_last, IN_clear, IN_ready,
      output OUT_ready, OUT_valid, OUT_data, OUT_last, OUT_count, OUT_carry
   );

   modport master (
      output IN_valid, IN_data, IN_last, IN_clear, IN_ready,
      input  OUT_ready, OUT_valid, OUT_data, OUT_last, OUT_count, OUT_carry
   );
endinterface

// File: rtl/prefix_stream_accum.sv
// prefix_stream_accum: registered running (inclusive) prefix sum per packet.
// It sits directly after the combinational prefix-sum adder.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : stream bundle (slave modport)
//     in  : IN_valid, IN_data, IN_last, IN_clear, IN_ready
//     out : OUT_ready (= !OUT_valid || IN_ready), OUT_valid, OUT_data
//           (sum mod 2^N), OUT_last, OUT_count (1-based, saturating),
//           OUT_carry (sticky carry-out within the packet)
module prefix_stream_accum #(
   parameter int unsigned N     = 32,
   parameter int unsigned CNT_W = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   prefix_stream_accum_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [N-1:0]     acc;
   logic [CNT_W-1:0] cnt;
   logic             carry;

   logic [N-1:0]     acc_base;
   logic [CNT_W-1:0] cnt_base;
   logic             carry_base;
   logic [N:0]       sum;
   logic [CNT_W-1:0] cnt_new;
   logic             carry_new;

   logic             out_valid;
   logic [N-1:0]     out_data;
   logic             out_last;
   logic [CNT_W-1:0] out_count;
   logic             out_carry;

   logic             out_ready;
   logic             accept;
   logic             xfer;

   assign out_ready = !out_valid || bus.IN_ready;
   assign accept    = bus.IN_valid && out_ready;
   assign xfer      = out_valid && bus.IN_ready;

   assign bus.OUT_ready = out_ready;
   assign bus.OUT_valid = out_valid;
   assign bus.OUT_data  = out_data;
   assign bus.OUT_last  = out_last;
   assign bus.OUT_count = out_count;
   assign bus.OUT_carry = out_carry;

   // A clear that coincides with an accept must act first. In that case the
   // beat starts a fresh packet, so the running state reads as empty.
   always_comb begin
      acc_base   = acc;
      cnt_base   = cnt;
      carry_base = carry;
      if (bus.IN_clear || state == IDLE) begin
         acc_base   = '0;
         cnt_base   = '0;
         carry_base = 1'b0;
      end
      sum       = {1'b0, acc_base} + {1'b0, bus.IN_data};
      carry_new = carry_base || sum[N];
      cnt_new   = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         carry     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_count <= '0;
         out_carry <= 1'b0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sum[N-1:0];
            out_last  <= bus.IN_last;
            out_count <= cnt_new;
            out_carry <= carry_new;
         end

         case (state)
            IDLE: begin
               if (accept && !bus.IN_last) begin
                  acc   <= sum[N-1:0];
                  cnt   <= cnt_new;
                  carry <= carry_new;
                  state <= RUN;
               end else begin
                  acc   <= '0;
                  cnt   <= '0;
                  carry <= 1'b0;
               end
            end
            RUN: begin
               if (accept && !bus.IN_last) begin
                  acc   <= sum[N-1:0];
                  cnt   <= cnt_new;
                  carry <= carry_new;
               end else if (accept || bus.IN_clear) begin
                  acc   <= '0;
                  cnt   <= '0;
                  carry <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
